// File: rtl/inst_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
//   WORD_W      : width of a program counter / fetch address
//   INST_W      : width of one instruction word
//   INST_BYTES  : PC increment between sequential fetches
//   fq_state_t  : fetch-queue control states
package inst_fetch_queue_pkg;

  localparam int WORD_W     = 64;
  localparam int INST_W     = 32;
  localparam int INST_BYTES = 4;

  typedef enum logic [1:0] {
    FQ_RESET_WAIT = 2'd0,
    FQ_RUN        = 2'd1,
    FQ_FLUSH      = 2'd2
  } fq_state_t;

  // Sequential fetch address; wraps modulo 2^WORD_W.
  function automatic logic [WORD_W-1:0] next_fetch_pc(input logic [WORD_W-1:0] pc);
    return pc + WORD_W'(INST_BYTES);
  endfunction

endpackage

// File: rtl/inst_fetch_queue_fq_fifo.sv
// fq_fifo: DEPTH x W circular buffer with head/tail pointers and occupancy.
//   clk, rst     : clock, synchronous active-high reset
//   clear        : empties the buffer (same effect as reset on pointers/count)
//   push         : write push_data at tail (caller guarantees not full)
//   push_data    : entry to write
//   pop          : drop the head entry (caller guarantees not empty)
//   head_data    : current head entry, forced to zero while empty
//   count        : number of valid entries, 0..DEPTH
module fq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head_data,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= push_data;
  end

  // Zero when empty so stale storage never shows on the outputs.
  assign head_data = (count != '0) ? mem[head] : '0;

endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: issues sequential instruction fetches, buffers returned
// instructions with their PCs, and handles branch redirects by flushing
// the queue and discarding responses to requests already in flight.
//   clk, rst                 : clock, synchronous active-high reset
//   redirect, redirect_pc    : flush request and new fetch address
//   imem_req_valid/addr/ready: fetch request channel to instruction memory
//   imem_rsp_valid/inst      : in-order responses from instruction memory
//   out_valid/pc/inst/ready  : instruction stream towards IF/ID
//   dbg_state                : current control state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. valid never depends combinationally on ready of the same channel;
// redirect and imem_rsp_valid are unconditional (no back-pressure).
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [WORD_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              imem_req_valid,
  output logic [WORD_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_inst,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_pc,
  output logic [INST_W-1:0] out_inst,
  input  logic              out_ready,
  output fq_state_t         dbg_state
);

  localparam int CW = $clog2(DEPTH) + 1;

  fq_state_t                  state, state_nxt;
  logic [WORD_W-1:0]          fetch_pc;
  logic [CW-1:0]              drop_cnt, drop_nxt;
  logic [CW-1:0]              outstanding;
  logic [CW-1:0]              count;
  logic [WORD_W-1:0]          shadow_pc;
  logic [WORD_W+INST_W-1:0]   head_entry;
  logic                       redirect_act;
  logic                       credit_ok;
  logic                       req_fire;
  logic                       rsp_accept;
  logic                       pop;

  // Redirects are ignored in RESET_WAIT; nothing is in flight there.
  assign redirect_act = redirect && (state != FQ_RESET_WAIT);

  // Every outstanding request owns a queue slot, so a response can always
  // be pushed without checking for full.
  assign credit_ok = ({1'b0, outstanding} + {1'b0, count}) < (CW+1)'(DEPTH);

  assign imem_req_valid = (state == FQ_RUN) && !redirect && credit_ok;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_accept = (state == FQ_RUN) && imem_rsp_valid && !redirect
                      && (outstanding != '0);

  assign out_valid = (count != '0) && !redirect;
  assign pop       = out_valid && out_ready;
  assign out_pc    = head_entry[INST_W +: WORD_W];
  assign out_inst  = head_entry[INST_W-1:0];
  assign dbg_state = state;

  // Request-address shadow: its occupancy is the outstanding-request count.
  fq_fifo #(.DEPTH(DEPTH), .W(WORD_W)) u_shadow_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect_act),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (rsp_accept),
    .head_data (shadow_pc),
    .count     (outstanding)
  );

  fq_fifo #(.DEPTH(DEPTH), .W(WORD_W + INST_W)) u_data_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect_act),
    .push      (rsp_accept),
    .push_data ({shadow_pc, imem_rsp_inst}),
    .pop       (pop),
    .head_data (head_entry),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FQ_RESET_WAIT;
      fetch_pc <= RESET_PC;
      drop_cnt <= '0;
    end else begin
      state    <= state_nxt;
      drop_cnt <= drop_nxt;
      if (redirect_act)  fetch_pc <= redirect_pc;
      else if (req_fire) fetch_pc <= next_fetch_pc(fetch_pc);
    end
  end

  // In RUN drop_cnt is zero; in FLUSH the shadow is empty. A redirect in
  // either state therefore turns everything still in flight into drops,
  // less the response (if any) being discarded this very cycle.
  always_comb begin
    state_nxt = state;
    drop_nxt  = drop_cnt;
    case (state)
      FQ_RESET_WAIT: state_nxt = FQ_RUN;
      FQ_RUN: begin
        if (redirect) begin
          drop_nxt  = (imem_rsp_valid && outstanding != '0) ? outstanding - CW'(1)
                                                            : outstanding;
          state_nxt = (drop_nxt != '0) ? FQ_FLUSH : FQ_RUN;
        end
      end
      FQ_FLUSH: begin
        if (imem_rsp_valid && drop_cnt != '0) drop_nxt = drop_cnt - CW'(1);
        state_nxt = (drop_nxt != '0) ? FQ_FLUSH : FQ_RUN;
      end
      default: state_nxt = FQ_RESET_WAIT;
    endcase
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;
  import inst_fetch_queue_pkg::*;

  logic              clk;
  logic              rst;
  logic              redirect;
  logic [WORD_W-1:0] redirect_pc;
  logic              imem_req_valid;
  logic [WORD_W-1:0] imem_req_addr;
  logic              imem_req_ready;
  logic              imem_rsp_valid;
  logic [INST_W-1:0] imem_rsp_inst;
  logic              out_valid;
  logic [WORD_W-1:0] out_pc;
  logic [INST_W-1:0] out_inst;
  logic              out_ready;
  fq_state_t         dbg_state;

  int tests = 0;
  int fails = 0;

  logic [WORD_W-1:0] exp_q[$];

  typedef struct {
    int                due;
    logic [WORD_W-1:0] addr;
  } mreq_t;
  mreq_t pend[$];
  int    mem_lat  = 1;
  int    hs_count = 0;

  inst_fetch_queue #(.DEPTH(4), .RESET_PC(64'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_inst  (imem_rsp_inst),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_ready      (out_ready),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [INST_W-1:0] inst_of(input logic [WORD_W-1:0] a);
    return a[31:0] ^ 32'hA500_0013;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- memory model (1 response per cycle, in order) ----------------
  initial begin : mem_model
    int                cyc;
    logic              pend_prev;
    logic [WORD_W-1:0] prev_addr;
    cyc            = 0;
    pend_prev      = 1'b0;
    prev_addr      = '0;
    imem_rsp_valid = 1'b0;
    imem_rsp_inst  = '0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (rst) begin
        pend.delete();
        imem_rsp_valid = 1'b0;
        pend_prev      = 1'b0;
      end else begin
        if (pend.size() > 0 && pend[0].due <= cyc) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_inst  = inst_of(pend[0].addr);
          void'(pend.pop_front());
        end else begin
          imem_rsp_valid = 1'b0;
        end
        if (pend_prev && imem_req_valid && !redirect)
          chk("addr_stable", imem_req_addr, prev_addr);
        if (imem_req_valid && imem_req_ready) begin
          pend.push_back('{cyc + mem_lat, imem_req_addr});
          hs_count++;
        end
        pend_prev = imem_req_valid && !imem_req_ready;
        prev_addr = imem_req_addr;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic [WORD_W-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_pop: got pc %h expected none", out_pc);
        end else begin
          e = exp_q.pop_front();
          chk("out_pc", out_pc, e);
          chk("out_inst", 64'(out_inst), 64'(inst_of(e)));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
  endtask

  // Leaves the bench at the negedge where rst drops: cycle 0.
  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b1;
    redirect       = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    imem_req_ready = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    hs_count = 0;
  endtask

  task automatic push_seq(input logic [WORD_W-1:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 64'(4 * i));
  endtask

  task automatic drain(input string name, input int budget, input bit rnd);
    int n;
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
      if (rnd) begin
        imem_req_ready = 1'($urandom_range(0, 1));
        out_ready      = 1'($urandom_range(0, 1));
      end
      n++;
    end
    out_ready = 1'b0;
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s_timeout: got %0d entries left expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst            = 1'b1;
    redirect       = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    out_ready      = 1'b0;

    // Sequential fetch, 1-cycle memory: first output in cycle 3, PC 0.
    mem_lat = 1;
    do_reset();
    out_ready = 1'b1;
    push_seq(64'h0, 8);
    #3;
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pc", out_pc, 64'h0);
    chk("rst_out_inst", 64'(out_inst), 64'h0);
    chk("rst_req_addr", imem_req_addr, 64'h0);
    chk("rst_state", 64'(dbg_state), 64'(FQ_RESET_WAIT));
    step(); #3;
    chk("c1_req_valid", 64'(imem_req_valid), 64'd1);
    chk("c1_req_addr", imem_req_addr, 64'h0);
    step(); #3;
    chk("c2_out_valid", 64'(out_valid), 64'd0);
    step(); #3;
    chk("c3_out_valid", 64'(out_valid), 64'd1);
    chk("c3_out_pc", out_pc, 64'h0);
    drain("seq", 200, 1'b0);

    // Decode stalled for 10 cycles: credit caps requests at DEPTH.
    mem_lat = 1;
    do_reset();
    push_seq(64'h0, 8);
    repeat (10) step();
    #3;
    chk("stall_req_count", 64'(hs_count), 64'd4);
    chk("stall_req_valid", 64'(imem_req_valid), 64'd0);
    chk("stall_out_valid", 64'(out_valid), 64'd1);
    chk("stall_out_pc", out_pc, 64'h0);
    step();
    out_ready = 1'b1;
    drain("stall", 200, 1'b0);

    // Redirect with 2 outstanding, 3-cycle memory: two drops in FLUSH.
    mem_lat = 3;
    do_reset();
    out_ready = 1'b1;
    push_seq(64'h100, 8);
    repeat (3) step();
    redirect    = 1'b1;
    redirect_pc = 64'h100;
    #3;
    chk("rd_outstanding", 64'(hs_count), 64'd2);
    chk("rd_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rd_out_valid", 64'(out_valid), 64'd0);
    step();
    redirect = 1'b0;
    #3;
    chk("rd_c4_state", 64'(dbg_state), 64'(FQ_FLUSH));
    chk("rd_c4_req_valid", 64'(imem_req_valid), 64'd0);
    step(); #3;
    chk("rd_c5_state", 64'(dbg_state), 64'(FQ_FLUSH));
    step(); #3;
    chk("rd_c6_state", 64'(dbg_state), 64'(FQ_RUN));
    chk("rd_c6_req_valid", 64'(imem_req_valid), 64'd1);
    chk("rd_c6_req_addr", imem_req_addr, 64'h100);
    drain("redirect", 300, 1'b0);

    // Redirect coinciding with a response and out_ready=1.
    mem_lat = 1;
    do_reset();
    out_ready = 1'b1;
    exp_q.push_back(64'h0);
    push_seq(64'h200, 8);
    repeat (4) step();
    redirect    = 1'b1;
    redirect_pc = 64'h200;
    #3;
    chk("rc_out_valid", 64'(out_valid), 64'd0);
    chk("rc_req_valid", 64'(imem_req_valid), 64'd0);
    step();
    redirect = 1'b0;
    #3;
    chk("rc_state", 64'(dbg_state), 64'(FQ_RUN));
    chk("rc_req_valid_after", 64'(imem_req_valid), 64'd1);
    chk("rc_req_addr_after", imem_req_addr, 64'h200);
    drain("redirect_rsp", 300, 1'b0);

    // Random request/output back-pressure: contiguous PCs, stable address.
    mem_lat = 1;
    do_reset();
    push_seq(64'h0, 20);
    drain("random", 800, 1'b1);

    // Reset mid-operation with a full credit window.
    mem_lat = 3;
    do_reset();
    repeat (5) step();
    #3;
    chk("mr_req_count", 64'(hs_count), 64'd4);
    chk("mr_req_valid", 64'(imem_req_valid), 64'd0);
    chk("mr_out_valid", 64'(out_valid), 64'd1);
    step();
    rst = 1'b1;
    step(); #3;
    chk("mr_out_valid_rst", 64'(out_valid), 64'd0);
    chk("mr_out_pc_rst", out_pc, 64'h0);
    chk("mr_out_inst_rst", 64'(out_inst), 64'h0);
    chk("mr_req_valid_rst", 64'(imem_req_valid), 64'd0);
    chk("mr_req_addr_rst", imem_req_addr, 64'h0);
    chk("mr_state_rst", 64'(dbg_state), 64'(FQ_RESET_WAIT));
    step();
    rst       = 1'b0;
    mem_lat   = 1;
    hs_count  = 0;
    out_ready = 1'b1;
    push_seq(64'h0, 4);
    drain("post_reset", 200, 1'b0);

    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    tests++;
    fails++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
